bin_to_bcd_digits: RTL and testbench
====================================

Name: bin_to_bcd_digits

Overview:
- Sequential binary-to-BCD converter using iterative shift-and-add-3 (double-dabble). Produces one 4-bit digit code per display position.
- Sits upstream of the per-digit seven-segment decoders and feeds them nibbles 0-9. Score and counter values from game logic pass through this block before reaching the HEX displays.
- One conversion per start request. Valid/done handshake, with saturation and leading-zero blanking flags.

Parameters:
- BIN_W, 14, width of binary input.
- DIGITS, 4, number of BCD digits produced; max representable value MAX = 10^DIGITS - 1.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a conversion; sampled only in IDLE.
- bin_in  in  BIN_W  unsigned binary value; captured on the accepting edge.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; bcd_out/overflow/blank valid from this cycle on.
- bcd_out  out  4*DIGITS  packed digits; digit i at bits [4i+3:4i], digit 0 = least significant.
- blank  out  DIGITS  bit i = 1 when digit i is a leading zero; bit 0 always 0.
- overflow  out  1  bin_in > MAX on the last accepted request.

Behaviour:
- Clock and reset: one clock (clock); reset synchronous, active-high (reset).
- Reset values: state=IDLE, busy=0, done=0, bcd_out=0, overflow=0, blank = all ones except bit 0.
- Reset mid-conversion: abandons the conversion, applies all reset values at that edge, and produces no done pulse.
- IDLE:
  - On an edge with start=1, capture bin_in into a BIN_W-bit shift register and clear a 4*DIGITS-bit BCD scratch register.
  - Load iteration counter with BIN_W, set an internal ovf flag = (bin_in > MAX), and go to SHIFT.
  - start=0: remain.
- SHIFT, each edge:
  - For every digit of the scratch register, add 3 if its value >= 5 (4-bit add, no carry out).
  - Then shift {scratch, binary} left by 1; the binary MSB enters scratch bit 0.
  - Decrement counter. On the edge completing the BIN_W-th iteration, go to DONE.
- DONE:
  - Entered with outputs registered on that same edge:
    - bcd_out = scratch, or all digits 9 if ovf.
    - overflow = ovf.
    - blank computed from the final digits: digit i blanked iff all digits i..DIGITS-1 are 0, i >= 1.
  - done=1 for exactly this one cycle. Next edge goes to IDLE unconditionally.
- Latency: done is high in the cycle after the edge that is BIN_W edges after the accepting edge (14 for defaults). With start held high, acceptances recur every BIN_W+2 edges.
- start while busy (SHIFT or DONE) is ignored; there is no queueing. bin_in changes while busy have no effect.
- Output hold: bcd_out, blank and overflow hold their values between done pulses and are not disturbed during a later conversion until its done edge.
- Values:
  - Value 0 gives bcd_out=0 and blank=1..10.
  - A value exactly MAX is not an overflow.
- Width rule: the scratch register never exceeds 9 per digit when bin_in <= MAX. On overflow, scratch content is don't-care and is replaced by saturation.
- Parameter requirements: BIN_W >= 1 and DIGITS >= 1. MAX comparison is done at width max(BIN_W, ceil(log2(MAX+1))) with no truncation.

Decomposition:
- Shared package/header: FSM state encoding (IDLE, SHIFT, DONE), BCD nibble width constant (4), the saturation digit constant (4'd9), and the MAX constant function of DIGITS.
- One sub-module: bcd_digit_adjust (4-bit in -> 4-bit out, add 3 when >= 5), combinational, instantiated DIGITS times via generate.
- Counter width is derived in-module as ceil(log2(BIN_W+1)).

Test Plan:
- Reset, then start with bin_in=0 -> done pulse 14 edges after accept; bcd_out=16'h0000, blank=4'b1110, overflow=0.
- bin_in=1234 -> bcd_out=16'h1234, blank=4'b0000. Then bin_in=7 -> bcd_out=16'h0007, blank=4'b1110. Exactly one done pulse per request.
- bin_in=9999 -> 16'h9999, overflow=0. bin_in=10000 and 16383 -> 16'h9999, overflow=1.
- Accept 4321, pulse start with bin_in=55 at edges +3 and +10 -> single done, bcd_out=16'h4321. A new start accepted only after returning to IDLE.
- Accept 5678, assert reset at edge +5 -> no done; outputs at reset values next cycle. Subsequent start with 42 -> 16'h0042, blank=4'b1100.
- start held high with bin_in=100 -> done pulses every 16 cycles, busy low for exactly one cycle between conversions, bcd_out stable at 16'h0100.

Source files
------------

// File: rtl/bin_to_bcd_digits_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package bin_to_bcd_digits_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  localparam int unsigned NIB_W     = 4;
  localparam logic [3:0]  SAT_DIGIT = 4'd9;

  // Largest value representable in the given number of decimal digits.
  function automatic longint unsigned bcd_max(input int unsigned digits);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_digits_adjust.sv
// Double-dabble digit correction: add 3 to a BCD nibble holding 5 or more.
module bcd_digit_adjust
  import bin_to_bcd_digits_pkg::*;
(
  input  logic [NIB_W-1:0] digit_i,
  output logic [NIB_W-1:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_digits.sv
// Iterative shift-and-add-3 binary-to-BCD converter with saturation and
// leading-zero blanking flags; one conversion per accepted start.
module bin_to_bcd_digits
  import bin_to_bcd_digits_pkg::*;
#(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [NIB_W*DIGITS-1:0] bcd_out,
  output logic [DIGITS-1:0]       blank,
  output logic                    overflow
);

  localparam int unsigned     BCD_W     = NIB_W * DIGITS;
  localparam longint unsigned MAX_VAL   = bcd_max(DIGITS);
  localparam int unsigned     MAX_W     = $clog2(MAX_VAL + 64'd1);
  localparam int unsigned     CMP_W     = (BIN_W > MAX_W) ? BIN_W : MAX_W;
  localparam logic [CMP_W-1:0] MAX_C    = CMP_W'(MAX_VAL);
  localparam int unsigned     CNT_W     = $clog2(BIN_W + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  state_e              state_q, state_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [BCD_W-1:0]    scr_q, scr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic                oflow_q, oflow_d;

  logic [BCD_W-1:0]    adj;
  logic [BCD_W-1:0]    shifted;
  logic [BCD_W-1:0]    final_digits;
  logic [DIGITS-1:0]   blank_calc;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (scr_q[g*NIB_W +: NIB_W]),
      .digit_o (adj[g*NIB_W +: NIB_W])
    );
  end

  // Final digits are taken from the post-shift value so the DONE edge can
  // register them directly.
  assign shifted      = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
  assign final_digits = ovf_q ? {DIGITS{SAT_DIGIT}} : shifted;

  always_comb begin
    logic zero_run;
    int unsigned idx;
    blank_calc = '0;
    zero_run   = 1'b1;
    idx        = 0;
    for (int unsigned k = 0; k + 1 < DIGITS; k++) begin
      idx             = DIGITS - 1 - k;
      zero_run        = zero_run & (final_digits[idx*NIB_W +: NIB_W] == 4'd0);
      blank_calc[idx] = zero_run;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    bcd_d   = bcd_q;
    blank_d = blank_q;
    oflow_d = oflow_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bin_d   = bin_in;
          scr_d   = '0;
          cnt_d   = CNT_W'(BIN_W);
          ovf_d   = CMP_W'(bin_in) > MAX_C;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        scr_d = shifted;
        bin_d = bin_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = final_digits;
          blank_d = blank_calc;
          oflow_d = ovf_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      bcd_q   <= '0;
      blank_q <= BLANK_RST;
      oflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      bcd_q   <= bcd_d;
      blank_q <= blank_d;
      oflow_q <= oflow_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign bcd_out  = bcd_q;
  assign blank    = blank_q;
  assign overflow = oflow_q;

endmodule

// File: tb/tb_bin_to_bcd_digits.sv
// Scoreboard bench for bin_to_bcd_digits: driver pushes model results on
// each accepted request, monitor checks them on every done pulse.
module tb_bin_to_bcd_digits;

  localparam int unsigned BIN_W  = 14;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned LAT    = 14;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] bin_in;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic [3:0]  blank;
  logic        overflow;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic        ovf;
    int unsigned acc;
  } exp_t;

  exp_t        sb[$];
  int          vectors    = 0;
  int          miscompares = 0;
  int unsigned cyc        = 0;
  bit          armed      = 1'b0;
  logic [15:0] hold_bcd;
  logic [3:0]  hold_blank;
  logic        hold_ovf;

  bin_to_bcd_digits #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .blank    (blank),
    .overflow (overflow)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference: decimal digits by division, saturation by clamping.
  function automatic exp_t model(input int unsigned v, input int unsigned acc);
    exp_t        e;
    int unsigned s, x, p;
    s = (v > 9999) ? 9999 : v;
    x = s;
    p = 1;
    e.bcd   = '0;
    e.blank = '0;
    for (int i = 0; i < 4; i++) begin
      e.bcd[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
      e.blank[i] = (i != 0) && (s < p);
      p = p * 10;
    end
    e.ovf = (v > 9999);
    e.acc = acc;
    return e;
  endfunction

  always @(negedge clock) begin
    if (armed) begin
      if (done) begin
        if (sb.size() == 0) begin
          flag("spurious_done");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("latency", 64'(cyc), 64'(e.acc + LAT));
          chk("bcd_out", 64'(bcd_out), 64'(e.bcd));
          chk("blank", 64'(blank), 64'(e.blank));
          chk("overflow", 64'(overflow), 64'(e.ovf));
          hold_bcd   = e.bcd;
          hold_blank = e.blank;
          hold_ovf   = e.ovf;
        end
      end else begin
        chk("hold_bcd", 64'(bcd_out), 64'(hold_bcd));
        chk("hold_blank", 64'(blank), 64'(hold_blank));
        chk("hold_ovf", 64'(overflow), 64'(hold_ovf));
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 64; i++) begin
      if (!busy) return;
      @(negedge clock);
    end
    flag("idle_timeout");
  endtask

  task automatic issue(input int unsigned v);
    wait_idle();
    start  = 1'b1;
    bin_in = 14'(v);
    @(posedge clock);
    @(negedge clock);
    sb.push_back(model(v, cyc));
    start  = 1'b0;
    bin_in = 14'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned prev_acc;
    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(negedge clock);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_bcd", 64'(bcd_out), 64'(0));
    chk("rst_blank", 64'(blank), 64'(4'b1110));
    chk("rst_ovf", 64'(overflow), 64'(0));
    reset      = 1'b0;
    hold_bcd   = '0;
    hold_blank = 4'b1110;
    hold_ovf   = 1'b0;
    armed      = 1'b1;

    issue(0);
    issue(1234);
    issue(7);
    issue(9999);
    issue(10000);
    issue(16383);

    // Starts during SHIFT must be ignored.
    issue(4321);
    repeat (2) @(negedge clock);
    start = 1'b1; bin_in = 14'd55;
    @(negedge clock);
    start = 1'b0;
    repeat (6) @(negedge clock);
    start = 1'b1; bin_in = 14'd55;
    @(negedge clock);
    start = 1'b0;
    wait_idle();

    // Reset mid-conversion: abandoned, no done, reset values restored.
    issue(5678);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    void'(sb.pop_back());
    hold_bcd   = '0;
    hold_blank = 4'b1110;
    hold_ovf   = 1'b0;
    @(negedge clock);
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    reset = 1'b0;
    issue(42);

    // Start held high: back-to-back acceptances.
    wait_idle();
    start    = 1'b1;
    bin_in   = 14'd100;
    prev_acc = 0;
    for (int k = 0; k < 3; k++) begin
      wait_idle();
      @(posedge clock);
      @(negedge clock);
      sb.push_back(model(100, cyc));
      if (k > 0) chk("period", 64'(cyc - prev_acc), 64'(BIN_W + 2));
      prev_acc = cyc;
    end
    start = 1'b0;

    for (int n = 0; n < 40; n++) begin
      int unsigned v;
      v = ($urandom_range(0, 3) == 0) ? $urandom_range(9990, 16383) : $urandom_range(0, 16383);
      issue(v);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clock);
    if (sb.size() != 0) flag("drain_timeout");
    repeat (2) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
